// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the receive DMA engine
package dma_pkg;

  localparam int         WORD_W           = 32;
  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;

  typedef enum logic [1:0] {
    LEN,
    INSTR,
    ACK,
    DATA
  } dma_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - gathers four bytes into a little-endian word
module byte_packer
  import dma_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  // Bytes enter at the top and move down, so the first byte ends up in [7:0].
  always_comb begin
    lane_d     = lane_q;
    shift_d    = shift_q;
    word_valid = 1'b0;
    word       = {in_byte, shift_q};
    if (in_valid) begin
      shift_d    = {in_byte, shift_q[23:8]};
      lane_d     = lane_q + 2'd1;
      word_valid = (lane_q == 2'd3);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - UART byte stream to program-load and data DMA strobes
module dma_controller
  import dma_pkg::*;
#(
  parameter int         CODE_WORDS = 1024,
  parameter logic [7:0] ACK_BYTE   = DEFAULT_ACK_BYTE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [7:0]        rdata,
  output logic              instr_ready,
  output logic              mem_ready,
  output logic [WORD_W-1:0] data,
  output logic              program_loaded,
  output logic              tx_start,
  output logic [7:0]        sdata,
  input  logic              tx_busy
);

  localparam logic [WORD_W-1:0] CODE_LIMIT = WORD_W'(CODE_WORDS);

  dma_state_t        state_q, state_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              instr_ready_q, instr_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              program_loaded_q, program_loaded_d;
  logic              tx_start_q, tx_start_d;

  logic              pack_valid;
  logic              pack_clear;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign pack_valid = rx_ready && ((state_q == LEN) || (state_q == INSTR));
  assign pack_clear = reset || (state_q == ACK) || (state_q == DATA);

  byte_packer u_packer (
    .clock      (clock),
    .clear      (pack_clear),
    .in_valid   (pack_valid),
    .in_byte    (rdata),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d          = state_q;
    n_d              = n_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    program_loaded_d = program_loaded_q;
    instr_ready_d    = 1'b0;
    mem_ready_d      = 1'b0;
    tx_start_d       = 1'b0;
    case (state_q)
      LEN: begin
        if (word_valid) begin
          n_d     = word;
          cnt_d   = '0;
          state_d = (word == '0) ? ACK : INSTR;
        end
      end
      INSTR: begin
        if (word_valid) begin
          cnt_d = cnt_q + 1'b1;
          // Words beyond the code segment are consumed but never strobed.
          if (cnt_q < CODE_LIMIT) begin
            instr_ready_d = 1'b1;
            data_d        = word;
          end
          if (cnt_d == n_q) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (rx_ready) begin
          mem_ready_d = 1'b1;
          data_d      = {24'd0, rdata};
        end
        if (!tx_busy) begin
          tx_start_d       = 1'b1;
          program_loaded_d = 1'b1;
          state_d          = DATA;
        end
      end
      DATA: begin
        if (rx_ready) begin
          mem_ready_d = 1'b1;
          data_d      = {24'd0, rdata};
        end
      end
      default: state_d = LEN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= LEN;
      n_q              <= '0;
      cnt_q            <= '0;
      data_q           <= '0;
      instr_ready_q    <= 1'b0;
      mem_ready_q      <= 1'b0;
      program_loaded_q <= 1'b0;
      tx_start_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      cnt_q            <= cnt_d;
      data_q           <= data_d;
      instr_ready_q    <= instr_ready_d;
      mem_ready_q      <= mem_ready_d;
      program_loaded_q <= program_loaded_d;
      tx_start_q       <= tx_start_d;
    end
  end

  assign instr_ready    = instr_ready_q;
  assign mem_ready      = mem_ready_q;
  assign data           = data_q;
  assign program_loaded = program_loaded_q;
  assign tx_start       = tx_start_q;
  assign sdata          = ACK_BYTE;

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - scoreboard bench for dma_controller
module tb_dma_controller;
  import dma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a = 1'b1, rx_a = 1'b0, tx_busy_a = 1'b0;
  logic [7:0]  rdata_a = 8'h00;
  logic        instr_a, mem_a, pl_a, txs_a;
  logic [31:0] data_a;
  logic [7:0]  sdata_a;

  logic        reset_b = 1'b1, rx_b = 1'b0, tx_busy_b = 1'b0;
  logic [7:0]  rdata_b = 8'h00;
  logic        instr_b, mem_b, pl_b, txs_b;
  logic [31:0] data_b;
  logic [7:0]  sdata_b;

  dma_controller dut_a (
    .clock(clk), .reset(reset_a), .rx_ready(rx_a), .rdata(rdata_a),
    .instr_ready(instr_a), .mem_ready(mem_a), .data(data_a),
    .program_loaded(pl_a), .tx_start(txs_a), .sdata(sdata_a), .tx_busy(tx_busy_a)
  );

  dma_controller #(.CODE_WORDS(2)) dut_b (
    .clock(clk), .reset(reset_b), .rx_ready(rx_b), .rdata(rdata_b),
    .instr_ready(instr_b), .mem_ready(mem_b), .data(data_b),
    .program_loaded(pl_b), .tx_start(txs_b), .sdata(sdata_b), .tx_busy(tx_busy_b)
  );

  typedef struct {
    int          kind;
    logic [31:0] value;
    int          at;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic compare_ev(input string tag, input ev_t e, input int kind, input logic [31:0] v);
    total++;
    if (e.kind == kind && e.value === v && e.at == cyc) passed++;
    else $display("FAIL %s event: got kind %0d data %h cycle %0d expected kind %0d data %h cycle %0d",
                  tag, kind, v, cyc, e.kind, e.value, e.at);
  endtask

  task automatic obs_a(input int kind, input logic [31:0] v);
    if (q_a.size() == 0) begin
      total++;
      $display("FAIL A unexpected: got kind %0d data %h cycle %0d expected no event", kind, v, cyc);
    end else begin
      compare_ev("A", q_a.pop_front(), kind, v);
    end
  endtask

  task automatic obs_b(input int kind, input logic [31:0] v);
    if (q_b.size() == 0) begin
      total++;
      $display("FAIL B unexpected: got kind %0d data %h cycle %0d expected no event", kind, v, cyc);
    end else begin
      compare_ev("B", q_b.pop_front(), kind, v);
    end
  endtask

  // kind 0 = instr_ready, 1 = mem_ready, 2 = tx_start
  always @(negedge clk) begin
    if (instr_a) obs_a(0, data_a);
    if (mem_a)   obs_a(1, data_a);
    if (txs_a)   obs_a(2, {24'd0, sdata_a});
    if (instr_b) obs_b(0, data_b);
    if (mem_b)   obs_b(1, data_b);
    if (txs_b)   obs_b(2, {24'd0, sdata_b});
  end

  task automatic exp_a(input int kind, input logic [31:0] v, input int at);
    ev_t e;
    e.kind = kind; e.value = v; e.at = at;
    q_a.push_back(e);
  endtask

  task automatic exp_b(input int kind, input logic [31:0] v, input int at);
    ev_t e;
    e.kind = kind; e.value = v; e.at = at;
    q_b.push_back(e);
  endtask

  task automatic send_a(input logic [7:0] b);
    rx_a = 1'b1; rdata_a = b;
    @(posedge clk); #1;
    rx_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_b = 1'b1; rdata_b = b;
    @(posedge clk); #1;
    rx_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_a();
    reset_a = 1'b1;
    idle(1);
    reset_a = 1'b0;
  endtask

  logic [31:0] words4 [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
  logic [7:0]  len4 [4]   = '{8'h04, 8'h00, 8'h00, 8'h00};
  logic [7:0]  beef [4]   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    idle(3);
    reset_a = 1'b0;

    check("rst_instr_ready", {31'd0, instr_a}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_a}, 32'd0);
    check("rst_data", data_a, 32'd0);
    check("rst_program_loaded", {31'd0, pl_a}, 32'd0);
    check("rst_tx_start", {31'd0, txs_a}, 32'd0);
    check("rst_sdata", {24'd0, sdata_a}, 32'h000000AA);

    // Four-word program load followed by the acknowledge.
    for (int i = 0; i < 4; i++) send_a(len4[i]);
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) begin
          exp_a(0, words4[w], cyc + 1);
          if (w == 3) exp_a(2, 32'h000000AA, cyc + 2);
        end
        send_a(8'(w * 4 + b + 1));
      end
    end
    idle(3);
    check("loaded_after_program", {31'd0, pl_a}, 32'd1);

    // Back-to-back data bytes after load.
    exp_a(1, 32'h00000041, cyc + 1);
    send_a(8'h41);
    exp_a(1, 32'h000000FF, cyc + 1);
    send_a(8'hFF);
    idle(3);

    // Zero-length program with the transmitter busy; a byte arrives during ACK.
    tx_busy_a = 1'b1;
    pulse_reset_a();
    check("loaded_cleared_by_reset", {31'd0, pl_a}, 32'd0);
    for (int i = 0; i < 4; i++) send_a(8'h00);
    exp_a(1, 32'h00000055, cyc + 1);
    send_a(8'h55);
    idle(20);
    check("loaded_low_while_busy", {31'd0, pl_a}, 32'd0);
    tx_busy_a = 1'b0;
    exp_a(2, 32'h000000AA, cyc + 1);
    idle(3);
    check("loaded_after_empty_program", {31'd0, pl_a}, 32'd1);

    // Reset mid-load drops the partial word and restarts length parsing.
    pulse_reset_a();
    send_a(8'h02); send_a(8'h00); send_a(8'h00); send_a(8'h00);
    send_a(8'h11); send_a(8'h22); send_a(8'h33);
    exp_a(0, 32'h44332211, cyc + 1);
    send_a(8'h44);
    send_a(8'h55); send_a(8'h66);
    pulse_reset_a();
    check("mid_reset_loaded", {31'd0, pl_a}, 32'd0);
    check("mid_reset_data", data_a, 32'd0);
    send_a(8'h01); send_a(8'h00); send_a(8'h00); send_a(8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        exp_a(0, 32'hDEADBEEF, cyc + 1);
        exp_a(2, 32'h000000AA, cyc + 2);
      end
      send_a(beef[i]);
    end
    idle(3);

    // Code segment of two words: the third word is consumed but not strobed.
    reset_b = 1'b0;
    send_b(8'h03); send_b(8'h00); send_b(8'h00); send_b(8'h00);
    for (int i = 1; i <= 12; i++) begin
      if (i == 4)  exp_b(0, 32'h04030201, cyc + 1);
      if (i == 8)  exp_b(0, 32'h08070605, cyc + 1);
      if (i == 12) exp_b(2, 32'h000000AA, cyc + 2);
      send_b(8'(i));
    end
    idle(3);
    check("b_loaded", {31'd0, pl_b}, 32'd1);

    for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) idle(1);
    while (q_a.size() != 0) begin
      ev_t e = q_a.pop_front();
      total++;
      $display("FAIL A missing: got none expected kind %0d data %h cycle %0d", e.kind, e.value, e.at);
    end
    while (q_b.size() != 0) begin
      ev_t e = q_b.pop_front();
      total++;
      $display("FAIL B missing: got none expected kind %0d data %h cycle %0d", e.kind, e.value, e.at);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
# dma_controller

Boot-time and run-time receive DMA engine that sits between the UART receiver and `MemoryControllerHub`. It converts the received byte stream into memory-hub DMA strobes: first a length-prefixed program image (`instr_ready`), then a continuous stream of input data (`mem_ready`). It also sends one acknowledge byte through the shared `UartTx` once the program is fully loaded.

## Interface
Parameters:
- `CODE_WORDS`, 1024: capacity of the code segment in words; instruction words beyond this are discarded.
- `ACK_BYTE`, 8'hAA: byte transmitted once the program load completes.

Ports:
- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `rx_ready` in 1: one-cycle pulse; `rdata` is valid in that cycle.
- `rdata` in 8: received UART byte.
- `instr_ready` out 1: one-cycle pulse; `data` is an instruction word.
- `mem_ready` out 1: one-cycle pulse; `data` is an input-data word.
- `data` out 32: word presented to the hub.
- `program_loaded` out 1: level; high from the DATA state onward.
- `tx_start` out 1: one-cycle pulse requesting transmission of `sdata`.
- `sdata` out 8: constant `ACK_BYTE`.
- `tx_busy` in 1: UartTx busy; `tx_start` is issued only while it is low.

## Operation
- States: LEN, INSTR, ACK, DATA. Reset state is LEN.
- LEN:
  - Assemble 4 bytes little-endian (first byte → bits [7:0]) into the 32-bit word count N.
  - After the 4th byte, go to INSTR; if N == 0, go directly to ACK.
- INSTR:
  - Assemble 4 bytes little-endian per word.
  - Per completed word, pulse `instr_ready` if fewer than `CODE_WORDS` words have been issued so far; otherwise drop the word silently.
  - After the N-th word, go to ACK.
  - Word counter is 32 bits and compares against N exactly. It does not wrap within any legal N.
- ACK:
  - In the first cycle with `tx_busy` == 0, pulse `tx_start` and go to DATA.
  - Bytes received while in ACK are handled exactly as in DATA.
- DATA:
  - Each received byte produces one `mem_ready` pulse with `data` = {24'b0, rdata}.
  - Remains in DATA until reset; `program_loaded` = 1.
- Simultaneous events: an `rx_ready` in the same cycle as the ACK `tx_start` is still forwarded as data.
- Reset mid-operation: return to LEN, clear the byte lane counter, word counter and N. A partial word is dropped. No pulses are issued in the reset cycle.
- Byte lane counter is 2 bits and wraps 3 → 0 on each completed word.

## Timing
- Reset values: `instr_ready`=0, `mem_ready`=0, `data`=0, `program_loaded`=0, `tx_start`=0, `sdata`=`ACK_BYTE`.
- Strobes and `data` are registered:
  - `instr_ready`/`mem_ready` pulse exactly one cycle, in the cycle after the `rx_ready` that completes the word (or byte in DATA).
  - `data` is valid in the same cycle as the strobe and holds its value until the next strobe.
- `instr_ready` and `mem_ready` are never high together.
- Throughput: one strobe per `rx_ready`-completed unit; back-to-back `rx_ready` on consecutive cycles must be accepted.
- `tx_start`:
  - Registered, one cycle.
  - Issued no earlier than the cycle after entering ACK.
  - Never issued again after reset deasserts, until a new program load.
- `program_loaded` rises in the same cycle as `tx_start`.

## Structure
- Package `dma_pkg`:
  - State enum `dma_state_t` {LEN, INSTR, ACK, DATA}.
  - Default `ACK_BYTE` constant.
  - Word width constant 32.
- Sub-module `byte_packer`:
  - Shifts 4 bytes into a little-endian word.
  - Outputs a `word_valid` pulse and the word.
  - Has a synchronous `clear` input used on reset and on state transitions.
- Top module holds the FSM, the N/word counters and the output registers.

## Test plan
- Send 04 00 00 00 then bytes 01..10 → 4 `instr_ready` pulses with `data` 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; then `tx_start` with `sdata`=0xAA; `program_loaded`=1.
- Send length 0 (00 00 00 00) with `tx_busy` held high 20 cycles → no `instr_ready`; `tx_start` fires the first cycle after `tx_busy` falls.
- After load, send 0x41, 0xFF back-to-back → `mem_ready` pulses on consecutive cycles with `data` 0x00000041, 0x000000FF; `instr_ready` stays 0.
- With `CODE_WORDS`=2, length 3 and 12 bytes → exactly 2 `instr_ready` pulses; the 3rd word is dropped; ACK is still sent after the 12th byte.
- Length 2, send 6 bytes, assert `reset` 1 cycle, then send length 1 plus 4 bytes 0xDEADBEEF LE → only one new `instr_ready` with 0xDEADBEEF; partial word discarded.
- Byte 0x55 arriving in ACK while `tx_busy`=1 → `mem_ready` with 0x00000055 before `tx_start`.
